// File: rtl/axis_serializer_arbiter_if.sv
// ---------------------------------------------------------------------------
// axis_serializer_arbiter_if
// Bundles the handshake and data signals around the round-robin arbiter that
// feeds the wide side of a serializer.
//
// Signals:
//   up_valid   [CHAN_NB]            per-channel valid from the requesters
//   up_ready   [CHAN_NB]            per-channel ready back to the requesters
//   up_data    [CHAN_NB*DATA_WIDTH] channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   up_last    [CHAN_NB]            per-channel end-of-burst flag
//   down_ready                      ready from the serializer (its up_ready)
//   down_valid / down_data / down_id / down_last   registered output stream
//
// Modports:
//   master : the environment side (requesters plus serializer)
//   slave  : the arbiter itself
// ---------------------------------------------------------------------------
interface axis_serializer_arbiter_if #(
  parameter int CHAN_NB    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = 2
);
  logic [CHAN_NB-1:0]            up_valid;
  logic [CHAN_NB-1:0]            up_ready;
  logic [CHAN_NB*DATA_WIDTH-1:0] up_data;
  logic [CHAN_NB-1:0]            up_last;
  logic                          down_ready;
  logic                          down_valid;
  logic [DATA_WIDTH-1:0]         down_data;
  logic [ID_WIDTH-1:0]           down_id;
  logic                          down_last;

  modport master (
    output up_valid, up_data, up_last, down_ready,
    input  up_ready, down_valid, down_data, down_id, down_last
  );

  modport slave (
    input  up_valid, up_data, up_last, down_ready,
    output up_ready, down_valid, down_data, down_id, down_last
  );
endinterface

// File: rtl/axis_serializer_arbiter.sv
// ---------------------------------------------------------------------------
// axis_serializer_arbiter
// Round-robin arbiter sharing one downstream serializer among CHAN_NB wide
// stream requesters. A grant is held for a whole burst (until the granted
// channel's last flag). Granted words are forwarded through one output
// register tagged with the channel id and the last flag.
//
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : axis_serializer_arbiter_if.slave (up_* requester side,
//          down_* serializer side)
//
// Optional feature macro: AXIS_ARB_BURST_LIMIT_EN
//   When defined, a grant also ends on the beat that brings the beat count
//   to BURST_MAX; that beat is forwarded with down_last=1 and the channel
//   resumes its burst on its next grant. When undefined only up_last ends a
//   grant and no beat counter exists.
// ---------------------------------------------------------------------------
module axis_serializer_arbiter #(
  parameter int CHAN_NB    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = 2,
  parameter int BURST_MAX  = 16
) (
  input logic                      clk,
  input logic                      rst,
  axis_serializer_arbiter_if.slave bus
);

  if ((CHAN_NB < 2) || ((2 ** ID_WIDTH) < CHAN_NB) || (BURST_MAX < 1)) begin : g_bad_cfg
    $error("axis_serializer_arbiter: illegal CHAN_NB/ID_WIDTH/BURST_MAX");
  end

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   grant_q, grant_d;
  logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
  logic                  down_valid_q, down_valid_d;
  logic [DATA_WIDTH-1:0] down_data_q, down_data_d;
  logic [ID_WIDTH-1:0]   down_id_q, down_id_d;
  logic                  down_last_q, down_last_d;

  logic [ID_WIDTH-1:0]   winner_s;
  logic                  found_s;
  logic [CHAN_NB-1:0]    up_ready_s;
  logic                  gvalid_s;
  logic                  glast_s;
  logic [DATA_WIDTH-1:0] gword_s;
  logic                  accept_s;
  logic                  seg_end_s;

`ifdef AXIS_ARB_BURST_LIMIT_EN
  localparam int CNT_W = $clog2(BURST_MAX + 1);
  logic [CNT_W-1:0] count_q, count_d;
`endif

  // Round-robin search: first valid channel starting at ptr, wrapping around.
  always_comb begin
    winner_s = '0;
    found_s  = 1'b0;
    for (int i = 0; i < CHAN_NB; i++) begin
      int idx;
      idx = (int'(ptr_q) + i) % CHAN_NB;
      if (!found_s && bus.up_valid[idx]) begin
        found_s  = 1'b1;
        winner_s = ID_WIDTH'(idx);
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Select the granted channel's signals and drive its ready. Ready only
  // looks at the output register, never at up_valid.
  always_comb begin
    gvalid_s   = 1'b0;
    glast_s    = 1'b0;
    gword_s    = '0;
    up_ready_s = '0;
    for (int i = 0; i < CHAN_NB; i++) begin
      if (grant_q == ID_WIDTH'(i)) begin
        gvalid_s      = bus.up_valid[i];
        glast_s       = bus.up_last[i];
        gword_s       = bus.up_data[i*DATA_WIDTH +: DATA_WIDTH];
        up_ready_s[i] = (state_q == GRANT) & (~down_valid_q | bus.down_ready);
      end else begin
        up_ready_s[i] = 1'b0;
      end
    end
  end

  assign accept_s = gvalid_s & (|up_ready_s);

`ifdef AXIS_ARB_BURST_LIMIT_EN
  // count_q holds beats already taken, so this beat makes count==BURST_MAX.
  assign seg_end_s = glast_s | (count_q == CNT_W'(BURST_MAX - 1));
`else
  assign seg_end_s = glast_s;
`endif

  // Next-state for the FSM, grant pointer and output register.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    ptr_d        = ptr_q;
    down_valid_d = down_valid_q;
    down_data_d  = down_data_q;
    down_id_d    = down_id_q;
    down_last_d  = down_last_q;
`ifdef AXIS_ARB_BURST_LIMIT_EN
    count_d      = count_q;
`endif

    case (state_q)
      IDLE: begin
        if (found_s) begin
          state_d = GRANT;
          grant_d = winner_s;
`ifdef AXIS_ARB_BURST_LIMIT_EN
          count_d = '0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
`ifdef AXIS_ARB_BURST_LIMIT_EN
        if (accept_s) begin
          count_d = count_q + CNT_W'(1);
        end else begin
          count_d = count_q;
        end
`endif
        if (accept_s && seg_end_s) begin
          state_d = IDLE;
          if (int'(grant_q) == (CHAN_NB - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = grant_q + ID_WIDTH'(1);
          end
        end else begin
          state_d = GRANT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // An accepted beat always finds the register free or draining this cycle.
    if (accept_s) begin
      down_valid_d = 1'b1;
      down_data_d  = gword_s;
      down_id_d    = grant_q;
      down_last_d  = seg_end_s;
    end else if (bus.down_ready) begin
      down_valid_d = 1'b0;
    end else begin
      down_valid_d = down_valid_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      ptr_q        <= '0;
      down_valid_q <= 1'b0;
      down_data_q  <= '0;
      down_id_q    <= '0;
      down_last_q  <= 1'b0;
`ifdef AXIS_ARB_BURST_LIMIT_EN
      count_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      ptr_q        <= ptr_d;
      down_valid_q <= down_valid_d;
      down_data_q  <= down_data_d;
      down_id_q    <= down_id_d;
      down_last_q  <= down_last_d;
`ifdef AXIS_ARB_BURST_LIMIT_EN
      count_q      <= count_d;
`endif
    end
  end

  assign bus.up_ready   = up_ready_s;
  assign bus.down_valid = down_valid_q;
  assign bus.down_data  = down_data_q;
  assign bus.down_id    = down_id_q;
  assign bus.down_last  = down_last_q;

endmodule

// File: tb/tb_axis_serializer_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axis_serializer_arbiter
// Self-checking bench: per-channel source queues drive randomized bursts,
// a behavioural model of the arbitration rules predicts ready, the output
// register and every forwarded word; directed phases cover reset, rotation,
// burst hold, backpressure, reset mid-burst and (with
// AXIS_ARB_BURST_LIMIT_EN) burst segmentation.
// ---------------------------------------------------------------------------
module tb_axis_serializer_arbiter;

  localparam int CHAN_NB    = 4;
  localparam int DATA_WIDTH = 16;
  localparam int ID_WIDTH   = 2;
`ifdef AXIS_ARB_BURST_LIMIT_EN
  localparam int BURST_MAX  = 4;
`else
  localparam int BURST_MAX  = 16;
`endif

  typedef struct {
    int          id;
    logic [15:0] data;
    logic        last;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axis_serializer_arbiter_if #(
    .CHAN_NB(CHAN_NB), .DATA_WIDTH(DATA_WIDTH), .ID_WIDTH(ID_WIDTH)
  ) ifc ();

  axis_serializer_arbiter #(
    .CHAN_NB(CHAN_NB), .DATA_WIDTH(DATA_WIDTH), .ID_WIDTH(ID_WIDTH),
    .BURST_MAX(BURST_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Source side: each entry is {last, data}.
  logic [16:0]        src_q [CHAN_NB][$];
  logic [CHAN_NB-1:0] vld_r = '0;
  logic               rdy_r = 1'b0;
  logic               rst_cmd = 1'b1;
  int                 rdy_mode = 1;   // 0 random, 1 high, 2 low
  int                 gap_pct = 0;
  int                 acc_ch = -1;
  int                 acc_cnt [CHAN_NB];

  // Reference model state.
  int          m_owner = -1;
  int          m_ptr   = 0;
  int          m_count = 0;
  logic        m_dv    = 1'b0;
  logic [15:0] m_data  = 16'h0000;
  int          m_id    = 0;
  logic        m_last  = 1'b0;

  obs_t log_q [$];
  obs_t exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_beat(input int c, input logic [15:0] d, input logic l);
    src_q[c].push_back({l, d});
  endtask

  task automatic expect_word(input int id, input logic [15:0] d, input logic l);
    obs_t o;
    o.id = id; o.data = d; o.last = l;
    exp_q.push_back(o);
  endtask

  // Drive inputs for the coming cycle (called just after the active edge).
  task automatic drive();
    if (acc_ch >= 0) begin
      void'(src_q[acc_ch].pop_front());
    end
    rst = rst_cmd;
    case (rdy_mode)
      0:       rdy_r = ($urandom_range(0, 99) < 70);
      1:       rdy_r = 1'b1;
      default: rdy_r = 1'b0;
    endcase
    ifc.down_ready = rdy_r;
    for (int c = 0; c < CHAN_NB; c++) begin
      if (!vld_r[c] || (c == acc_ch)) begin
        vld_r[c] = (src_q[c].size() > 0) && ($urandom_range(0, 99) >= gap_pct);
      end
      if (vld_r[c]) begin
        ifc.up_data[c*DATA_WIDTH +: DATA_WIDTH] = src_q[c][0][15:0];
        ifc.up_last[c] = src_q[c][0][16];
      end else begin
        ifc.up_data[c*DATA_WIDTH +: DATA_WIDTH] = 16'($urandom);
        ifc.up_last[c] = 1'($urandom);
      end
    end
    ifc.up_valid = vld_r;
    acc_ch = -1;
  endtask

  // Compare the DUT with the model, then advance the model by one clock.
  task automatic model_eval();
    logic [CHAN_NB-1:0] exp_ur;
    logic [16:0]        w;
    logic               seg;
    obs_t               o;
    exp_ur = '0;
    if ((m_owner >= 0) && (!m_dv || rdy_r)) exp_ur[m_owner] = 1'b1;
    check_eq("up_ready", 32'(ifc.up_ready), 32'(exp_ur));
    check_eq("down_valid", 32'(ifc.down_valid), 32'(m_dv));
    if (m_dv) begin
      check_eq("down_data", 32'(ifc.down_data), 32'(m_data));
      check_eq("down_id", 32'(ifc.down_id), m_id);
      check_eq("down_last", 32'(ifc.down_last), 32'(m_last));
    end
    if (ifc.down_valid && rdy_r) begin
      o.id = int'(ifc.down_id); o.data = ifc.down_data; o.last = ifc.down_last;
      log_q.push_back(o);
    end
    acc_ch = -1;
    if ((m_owner >= 0) && exp_ur[m_owner] && vld_r[m_owner]) begin
      acc_ch = m_owner;
      acc_cnt[m_owner]++;
    end
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_count = 0;
      m_dv = 1'b0; m_data = 16'h0000; m_id = 0; m_last = 1'b0;
    end else if (acc_ch >= 0) begin
      w   = src_q[acc_ch][0];
      seg = w[16];
`ifdef AXIS_ARB_BURST_LIMIT_EN
      if ((m_count + 1) == BURST_MAX) seg = 1'b1;
`endif
      m_dv = 1'b1; m_data = w[15:0]; m_id = acc_ch; m_last = seg;
      m_count++;
      if (seg) begin
        m_ptr   = (acc_ch + 1) % CHAN_NB;
        m_owner = -1;
      end
    end else begin
      if (rdy_r) m_dv = 1'b0;
      if (m_owner < 0) begin
        for (int k = 0; k < CHAN_NB; k++) begin
          int c;
          c = (m_ptr + k) % CHAN_NB;
          if (vld_r[c]) begin
            m_owner = c;
            m_count = 0;
            break;
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    model_eval();
  endtask

  function automatic bit model_idle();
    bit idle;
    idle = (m_owner < 0) && !m_dv && (vld_r == '0);
    for (int c = 0; c < CHAN_NB; c++) begin
      if (src_q[c].size() != 0) idle = 1'b0;
    end
    return idle;
  endfunction

  task automatic drain();
    int n;
    n = 0;
    while (!model_idle() && (n < 1000)) begin
      step();
      n++;
    end
    check_eq("drain_done", 32'(model_idle()), 32'd1);
  endtask

  // Compare the observed words from index base on against exp_q.
  task automatic compare_log(input string tag, input int base);
    int n;
    n = log_q.size() - base;
    check_eq({tag, "_len"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < n) begin
        check_eq({tag, "_id"}, log_q[base+i].id, exp_q[i].id);
        check_eq({tag, "_data"}, 32'(log_q[base+i].data), 32'(exp_q[i].data));
        check_eq({tag, "_last"}, 32'(log_q[base+i].last), 32'(exp_q[i].last));
      end
    end
    exp_q.delete();
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int target;
    int n;
    for (int c = 0; c < CHAN_NB; c++) acc_cnt[c] = 0;

    // Reset with every channel valid, then strict rotation of 1-beat bursts.
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < CHAN_NB; c++) push_beat(c, 16'(16'h1000 + c), 1'b1);
    end
    rst_cmd = 1'b1; rdy_mode = 1; gap_pct = 0;
    drive();
    repeat (3) step();
    rst_cmd = 1'b0;
    drain();
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < CHAN_NB; c++) expect_word(c, 16'(16'h1000 + c), 1'b1);
    end
    compare_log("rr", 0);

    // Burst hold: ch2 burst stays contiguous; after it, ch3 is empty so ch0.
    log_q.delete();
    push_beat(0, 16'h00B0, 1'b1);
    push_beat(0, 16'h00B1, 1'b1);
    push_beat(1, 16'h00C0, 1'b1);
    push_beat(2, 16'h00A0, 1'b0);
    push_beat(2, 16'h00A1, 1'b0);
    push_beat(2, 16'h00A2, 1'b1);
    drain();
    expect_word(0, 16'h00B0, 1'b1);
    expect_word(1, 16'h00C0, 1'b1);
    expect_word(2, 16'h00A0, 1'b0);
    expect_word(2, 16'h00A1, 1'b0);
    expect_word(2, 16'h00A2, 1'b1);
    expect_word(0, 16'h00B1, 1'b1);
    compare_log("hold", 0);

    // Backpressure: down_ready low for 5 cycles in the middle of a burst.
    log_q.delete();
    for (int i = 0; i < 6; i++) push_beat(3, 16'(16'h0D00 + i), (i == 5));
    repeat (3) step();
    rdy_mode = 2;
    repeat (5) step();
    rdy_mode = 1;
    drain();
    for (int i = 0; i < 6; i++) expect_word(3, 16'(16'h0D00 + i), (i == 5));
    compare_log("bp", 0);

    // Reset after beat 2 of a 4-beat ch1 burst.
    log_q.delete();
    for (int i = 0; i < 4; i++) push_beat(1, 16'(16'h0E10 + i), (i == 3));
    push_beat(2, 16'h0E20, 1'b1);
    push_beat(3, 16'h0E30, 1'b1);
    target = acc_cnt[1] + 2;
    n = 0;
    while ((acc_cnt[1] < target) && (n < 100)) begin
      step();
      n++;
    end
    check_eq("rst_mid_reach", 32'(acc_cnt[1] >= target), 32'd1);
    rst_cmd = 1'b1;
    step();
    rst_cmd = 1'b0;
    step();
    check_eq("rst_mid_dv", 32'(ifc.down_valid), 32'd0);
    base = log_q.size();
    drain();
    expect_word(1, 16'h0E13, 1'b1);
    expect_word(2, 16'h0E20, 1'b1);
    expect_word(3, 16'h0E30, 1'b1);
    compare_log("rst_mid", base);

    // Randomized traffic with random backpressure and rare resets.
    rdy_mode = 0; gap_pct = 30;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < CHAN_NB; c++) begin
        if ((src_q[c].size() < 4) && ($urandom_range(0, 9) == 0)) begin
          int len;
          len = $urandom_range(1, 6);
          for (int i = 0; i < len; i++) push_beat(c, 16'($urandom), (i == len - 1));
        end
      end
      rst_cmd = ($urandom_range(0, 499) == 0);
      step();
    end
    rst_cmd = 1'b0; rdy_mode = 1; gap_pct = 0;
    drain();

`ifdef AXIS_ARB_BURST_LIMIT_EN
    // Burst limit: a 6-beat ch0 burst is split 4 + 2 around ch1's burst.
    rst_cmd = 1'b1;
    step();
    rst_cmd = 1'b0;
    log_q.delete();
    for (int i = 0; i < 6; i++) push_beat(0, 16'(16'h0F00 + i), (i == 5));
    push_beat(1, 16'h0F10, 1'b0);
    push_beat(1, 16'h0F11, 1'b1);
    drain();
    for (int i = 0; i < 4; i++) expect_word(0, 16'(16'h0F00 + i), (i == 3));
    expect_word(1, 16'h0F10, 1'b0);
    expect_word(1, 16'h0F11, 1'b1);
    expect_word(0, 16'h0F04, 1'b0);
    expect_word(0, 16'h0F05, 1'b1);
    compare_log("limit", 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
